// File: rtl/mobility_pkg.sv
// Shared types and widths for the mobility board's ultrasonic scan path.
package mobility_pkg;

   localparam int DIST_W  = 16;
   localparam int TIMER_W = 22;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_START,
      WAIT_DONE,
      CAPTURE,
      GUARD
   } seq_state_e;

endpackage

// File: rtl/ultrasonic_scan_sequencer_if.sv
// Sensor-side bundle between the scan sequencer (master) and the ultrasonic_sensor array (slave).
interface ultrasonic_scan_sequencer_if
   import mobility_pkg::*;
#(
   parameter int N_SENSORS = 4
);

   logic [N_SENSORS-1:0]             sens_trig;
   logic [N_SENSORS-1:0]             sens_busy;
   logic [N_SENSORS-1:0][DIST_W-1:0] sens_distance;
   logic [N_SENSORS-1:0]             sens_err;

   modport master (
      output sens_trig,
      input  sens_busy,
      input  sens_distance,
      input  sens_err
   );

   modport slave (
      input  sens_trig,
      output sens_busy,
      output sens_distance,
      output sens_err
   );

endinterface

// File: rtl/ultrasonic_result_reg.sv
// Per-sensor result holder: last good distance, valid/err flags and the obstacle compare.
module ultrasonic_result_reg
   import mobility_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_i,
   input  logic              bad_i,
   input  logic [DIST_W-1:0] dist_i,
   input  logic [DIST_W-1:0] thresh_i,
   output logic [DIST_W-1:0] dist_o,
   output logic              valid_o,
   output logic              err_o,
   output logic              obstacle_o
);

   logic [DIST_W-1:0] dist_q;
   logic              valid_q;
   logic              err_q;

   // A failed measurement keeps the previous distance but marks it stale.
   always_ff @(posedge clk) begin
      if (rst) begin
         dist_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (ld_i) begin
         if (bad_i) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
         end else begin
            dist_q  <= dist_i;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
         end
      end
   end

   assign dist_o     = dist_q;
   assign valid_o    = valid_q;
   assign err_o      = err_q;
   assign obstacle_o = valid_q && (dist_q < thresh_i);

endmodule

// File: rtl/ultrasonic_scan_sequencer.sv
// Round-robin ping scheduler: fires one ultrasonic sensor at a time, captures its result,
// then waits out a guard interval so residual echoes cannot reach the next sensor.
module ultrasonic_scan_sequencer
   import mobility_pkg::*;
#(
   parameter int N_SENSORS     = 4,
   parameter int GUARD_CYCLES  = 2_500_000,
   parameter int START_TIMEOUT = 8,
   parameter int DONE_TIMEOUT  = 4_000_000
) (
   input  logic                             clk50,
   input  logic                             rst,
   input  logic                             enable,
   input  logic [DIST_W-1:0]                obstacle_thresh,
   ultrasonic_scan_sequencer_if.master      sens,
   output logic [N_SENSORS-1:0][DIST_W-1:0] dist_out,
   output logic [N_SENSORS-1:0]             valid,
   output logic [N_SENSORS-1:0]             err_out,
   output logic [N_SENSORS-1:0]             obstacle,
   output logic [$clog2(N_SENSORS)-1:0]     cur_sensor,
   output logic                             scan_done
);

   localparam int IDX_W = $clog2(N_SENSORS);
   localparam logic [IDX_W-1:0]   LAST      = IDX_W'(N_SENSORS - 1);
   localparam logic [TIMER_W-1:0] START_LIM = TIMER_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
   localparam logic [TIMER_W-1:0] DONE_LIM  = TIMER_W'((DONE_TIMEOUT  > 0) ? DONE_TIMEOUT  - 1 : 0);
   localparam logic [TIMER_W-1:0] GUARD_LIM = TIMER_W'((GUARD_CYCLES  > 0) ? GUARD_CYCLES  - 1 : 0);
   localparam logic [N_SENSORS-1:0] ONE_HOT0 = N_SENSORS'(1);

   seq_state_e           state_q;
   logic [IDX_W-1:0]     cur_q;
   logic [TIMER_W-1:0]   timer_q;
   logic [TIMER_W-1:0]   timer_inc;
   logic                 fail_q;
   logic [N_SENSORS-1:0] trig_q;
   logic                 scan_done_q;
   logic                 cur_busy;
   logic                 cap;
   logic                 bad;

   assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
   assign cur_busy  = sens.sens_busy[cur_q];
   assign cap       = (state_q == CAPTURE);
   assign bad       = fail_q | sens.sens_err[cur_q];

   // Timers compare against LIM = N-1 because the entry cycle counts as cycle one.
   always_ff @(posedge clk50) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         timer_q     <= '0;
         fail_q      <= 1'b0;
         trig_q      <= '0;
         scan_done_q <= 1'b0;
      end else begin
         trig_q      <= '0;
         scan_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable && !cur_busy) begin
                  trig_q  <= ONE_HOT0 << cur_q;
                  state_q <= TRIG;
               end
            end
            TRIG: begin
               timer_q <= '0;
               state_q <= WAIT_START;
            end
            WAIT_START: begin
               if (cur_busy) begin
                  timer_q <= '0;
                  state_q <= WAIT_DONE;
               end else if (timer_q >= START_LIM) begin
                  fail_q  <= 1'b1;
                  state_q <= CAPTURE;
               end else begin
                  timer_q <= timer_inc;
               end
            end
            WAIT_DONE: begin
               if (!cur_busy) begin
                  state_q <= CAPTURE;
               end else if (timer_q >= DONE_LIM) begin
                  fail_q  <= 1'b1;
                  state_q <= CAPTURE;
               end else begin
                  timer_q <= timer_inc;
               end
            end
            CAPTURE: begin
               scan_done_q <= (cur_q == LAST);
               timer_q     <= '0;
               fail_q      <= 1'b0;
               state_q     <= GUARD;
            end
            GUARD: begin
               if (timer_q >= GUARD_LIM) begin
                  timer_q <= '0;
                  cur_q   <= (cur_q == LAST) ? '0 : cur_q + 1'b1;
                  state_q <= IDLE;
               end else begin
                  timer_q <= timer_inc;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_res
      ultrasonic_result_reg u_res (
         .clk        (clk50),
         .rst        (rst),
         .ld_i       (cap && (cur_q == IDX_W'(g))),
         .bad_i      (bad),
         .dist_i     (sens.sens_distance[g]),
         .thresh_i   (obstacle_thresh),
         .dist_o     (dist_out[g]),
         .valid_o    (valid[g]),
         .err_o      (err_out[g]),
         .obstacle_o (obstacle[g])
      );
   end

   assign sens.sens_trig = trig_q;
   assign cur_sensor     = cur_q;
   assign scan_done      = scan_done_q;

endmodule

// File: tb/tb_ultrasonic_scan_sequencer.sv
// Directed bench for the scan sequencer with behavioural ultrasonic sensor models.
module tb_ultrasonic_scan_sequencer;
   import mobility_pkg::*;

   localparam int N = 4;

   logic                     clk50;
   logic                     rst;
   logic                     enable;
   logic [DIST_W-1:0]        obstacle_thresh;
   logic [N-1:0][DIST_W-1:0] dist_out;
   logic [N-1:0]             valid;
   logic [N-1:0]             err_out;
   logic [N-1:0]             obstacle;
   logic [1:0]               cur_sensor;
   logic                     scan_done;

   ultrasonic_scan_sequencer_if #(.N_SENSORS(N)) sif ();

   ultrasonic_scan_sequencer #(
      .N_SENSORS     (N),
      .GUARD_CYCLES  (20),
      .START_TIMEOUT (8),
      .DONE_TIMEOUT  (100)
   ) dut (
      .clk50           (clk50),
      .rst             (rst),
      .enable          (enable),
      .obstacle_thresh (obstacle_thresh),
      .sens            (sif.master),
      .dist_out        (dist_out),
      .valid           (valid),
      .err_out         (err_out),
      .obstacle        (obstacle),
      .cur_sensor      (cur_sensor),
      .scan_done       (scan_done)
   );

   initial clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   // Sensor models: busy rises on the negedge that sees trig, falls blen negedges later.
   int              blen    [N];
   bit              nostart [N];
   bit              hold    [N];
   bit              eval    [N];
   logic [DIST_W-1:0] dval  [N];
   int              cnt     [N];
   logic [N-1:0]    bsy_r;

   always_comb begin
      sif.sens_busy     = '0;
      sif.sens_err      = '0;
      sif.sens_distance = '0;
      for (int i = 0; i < N; i++) begin
         sif.sens_busy[i]     = bsy_r[i] | hold[i];
         sif.sens_err[i]      = eval[i];
         sif.sens_distance[i] = dval[i];
      end
   end

   always @(negedge clk50) begin
      for (int i = 0; i < N; i++) begin
         if (sif.sens_trig[i] && !nostart[i]) begin
            bsy_r[i] = 1'b1;
            cnt[i]   = blen[i];
         end else if (cnt[i] > 0) begin
            cnt[i] = cnt[i] - 1;
            if (cnt[i] == 0) bsy_r[i] = 1'b0;
         end
      end
   end

   int viol;
   always @(negedge clk50) if ($countones(sif.sens_trig) > 1) viol++;

   int checks;
   int fails;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic wait_trig(input int idx, input int maxc, input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < maxc && !seen; c++) begin
         tick();
         seen = sif.sens_trig[idx];
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   task automatic wait_done(input int maxc, input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < maxc && !seen; c++) begin
         tick();
         seen = scan_done;
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   initial begin
      int n;
      int trig_seen;
      checks = 0;
      fails  = 0;
      viol   = 0;
      bsy_r  = '0;
      for (int i = 0; i < N; i++) begin
         blen[i] = 5; nostart[i] = 0; hold[i] = 0; eval[i] = 0; cnt[i] = 0;
      end
      dval[0] = 16'd100; dval[1] = 16'd200; dval[2] = 16'd300; dval[3] = 16'd400;
      rst = 1'b1;
      enable = 1'b0;
      obstacle_thresh = 16'd250;

      // Reset state
      repeat (3) tick();
      chk("rst_dist",   64'(dist_out),      64'd0);
      chk("rst_valid",  64'(valid),         64'd0);
      chk("rst_err",    64'(err_out),       64'd0);
      chk("rst_obst",   64'(obstacle),      64'd0);
      chk("rst_cur",    64'(cur_sensor),    64'd0);
      chk("rst_done",   64'(scan_done),     64'd0);
      chk("rst_trig",   64'(sif.sens_trig), 64'd0);
      rst = 1'b0;
      tick();
      chk("idle_no_trig", 64'(sif.sens_trig), 64'd0);

      // Normal scan 100/200/300/400, thresh 250
      enable = 1'b1;
      wait_trig(0, 5, "scan1_trig0");
      n = 0;
      while (!valid[0] && n < 50) begin tick(); n++; end
      chk("scan1_lat0", 64'(n), 64'd7);
      wait_done(300, "scan1_done");
      chk("scan1_dist",  64'(dist_out), {16'd400, 16'd300, 16'd200, 16'd100});
      chk("scan1_valid", 64'(valid),    64'hF);
      chk("scan1_err",   64'(err_out),  64'h0);
      chk("scan1_obst",  64'(obstacle), 64'h3);
      chk("scan1_cur",   64'(cur_sensor), 64'd3);
      tick();
      chk("scan1_done_pulse", 64'(scan_done), 64'd0);
      obstacle_thresh = 16'd300;
      #1 chk("thresh300_obst", 64'(obstacle), 64'h3);
      obstacle_thresh = 16'd301;
      #1 chk("thresh301_obst", 64'(obstacle), 64'h7);
      obstacle_thresh = 16'd250;

      // Sensor 2 never raises busy
      nostart[2] = 1;
      wait_trig(2, 200, "nostart_trig2");
      n = 0;
      while (!err_out[2] && n < 50) begin tick(); n++; end
      chk("nostart_lat", 64'(n), 64'd10);
      wait_done(200, "nostart_done");
      chk("nostart_err",   64'(err_out),     64'h4);
      chk("nostart_valid", 64'(valid),       64'hB);
      chk("nostart_dist2", 64'(dist_out[2]), 64'd300);

      // Sensor 1 reports err, then recovers with 150; equality boundary on sensors 0/3
      nostart[2] = 0;
      eval[1] = 1;
      wait_done(300, "err1_done");
      chk("err1_err",   64'(err_out),     64'h2);
      chk("err1_valid", 64'(valid),       64'hD);
      chk("err1_dist1", 64'(dist_out[1]), 64'd200);
      eval[1] = 0;
      dval[0] = 16'd250; dval[1] = 16'd150; dval[3] = 16'd249;
      wait_done(300, "rec_done");
      chk("rec_valid", 64'(valid),    64'hF);
      chk("rec_err",   64'(err_out),  64'h0);
      chk("rec_dist",  64'(dist_out), {16'd249, 16'd300, 16'd150, 16'd250});
      chk("rec_obst",  64'(obstacle), 64'hA);

      // Reset during WAIT_DONE of sensor 2, sensor 0 held busy afterwards
      blen[2] = 30;
      wait_trig(2, 200, "rstmid_trig2");
      repeat (3) tick();
      hold[0] = 1;
      rst = 1'b1;
      tick();
      chk("rstmid_dist",  64'(dist_out),   64'd0);
      chk("rstmid_valid", 64'(valid),      64'd0);
      chk("rstmid_err",   64'(err_out),    64'd0);
      chk("rstmid_obst",  64'(obstacle),   64'd0);
      chk("rstmid_cur",   64'(cur_sensor), 64'd0);
      chk("rstmid_trig",  64'(sif.sens_trig), 64'd0);
      rst = 1'b0;
      trig_seen = 0;
      repeat (10) begin tick(); if (sif.sens_trig != 0) trig_seen++; end
      chk("hold_no_trig", 64'(trig_seen), 64'd0);
      hold[0] = 0;
      wait_trig(0, 5, "hold_release_trig0");

      // Enable dropped during WAIT_DONE of sensor 1
      blen[1] = 10;
      wait_trig(1, 100, "endrop_trig1");
      repeat (3) tick();
      enable = 1'b0;
      trig_seen = 0;
      repeat (60) begin tick(); if (sif.sens_trig != 0) trig_seen++; end
      chk("endrop_no_trig", 64'(trig_seen),   64'd0);
      chk("endrop_cur",     64'(cur_sensor),  64'd2);
      chk("endrop_valid",   64'(valid),       64'h3);
      chk("endrop_dist1",   64'(dist_out[1]), 64'd150);
      chk("endrop_dist0",   64'(dist_out[0]), 64'd250);
      chk("endrop_err",     64'(err_out),     64'h0);

      chk("trig_onehot", 64'(viol), 64'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/ultrasonic_scan_sequencer.md
# ultrasonic_scan_sequencer

Round-robin scheduler that sits directly upstream of the mobility board's `ultrasonic_sensor` instances. It fires one sensor at a time so that echoes cannot crosstalk, and waits for that sensor to finish. It captures the sensor's distance and error, then publishes per-sensor results with an obstacle flag to the mobility controller. An inter-ping guard interval lets residual echoes die out before the next sensor fires.

## Interface
Parameters:
- `N_SENSORS`, default 4: number of sensors scanned (≥2).
- `GUARD_CYCLES`, default 2_500_000: idle cycles after each measurement (50 ms at 50 MHz).
- `START_TIMEOUT`, default 8: max cycles from `sens_trig` until `sens_busy` must rise.
- `DONE_TIMEOUT`, default 4_000_000: max cycles `sens_busy` may stay high (80 ms).

Ports:
- `clk50` in 1: 50 MHz system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level; scanning runs while high.
- `obstacle_thresh` in 16: distance threshold, in sensor counts.
- `sens_trig` out N_SENSORS: one-cycle start pulse to each sensor's `trig`.
- `sens_busy` in N_SENSORS: sensor `busy` outputs.
- `sens_distance` in 16*N_SENSORS: sensor `distance` outputs; sensor i occupies bits [16i+15:16i].
- `sens_err` in N_SENSORS: sensor `err` outputs.
- `dist_out` out 16*N_SENSORS: last good distance per sensor.
- `valid` out N_SENSORS: `dist_out[i]` is from the most recent measurement of sensor i.
- `err_out` out N_SENSORS: most recent measurement of sensor i failed.
- `obstacle` out N_SENSORS: `valid[i] && dist_out[i] < obstacle_thresh`.
- `cur_sensor` out ceil(log2 N): index of the sensor being serviced.
- `scan_done` out 1: one-cycle pulse when the last sensor's result is captured.

## Operation
- Reset: all outputs 0, `cur_sensor`=0, state IDLE, timers 0.
- IDLE: if `enable && !sens_busy[cur_sensor]`, go to TRIG. A busy sensor left over from a reset mid-flight blocks the start.
- TRIG: drive `sens_trig[cur_sensor]`=1 for exactly this cycle, clear timer, go to WAIT_START.
- WAIT_START: when `sens_busy[cur_sensor]`=1, clear timer and go to WAIT_DONE. If the timer reaches START_TIMEOUT, set the failure flag and go to CAPTURE.
- WAIT_DONE: when `sens_busy[cur_sensor]`=0, go to CAPTURE. If the timer reaches DONE_TIMEOUT, set the failure flag and go to CAPTURE.
- CAPTURE, one cycle:
  - On failure or `sens_err[cur_sensor]`=1: `err_out[i]`=1, `valid[i]`=0, and `dist_out[i]` is held.
  - Otherwise: `dist_out[i]` = sensor distance, `valid[i]`=1, `err_out[i]`=0.
  - If i = N_SENSORS−1, pulse `scan_done`.
  - Then go to GUARD, clear the timer, and clear the failure flag.
- GUARD: count GUARD_CYCLES. Then advance `cur_sensor` (wrapping N_SENSORS−1 → 0) and go to IDLE.
- `enable` falling mid-measurement: the current sensor is completed through CAPTURE and GUARD, then the block idles. Results are retained.
- `obstacle` is combinational from registered `dist_out`, `valid` and the live `obstacle_thresh`. Equal to threshold means no obstacle.
- Timers are 22-bit saturating; no arithmetic wrap.

## Timing
- `sens_trig` rises the cycle after IDLE sees the start conditions.
- The sensor samples on `negedge clk50`, so `sens_busy` is expected within 1–2 cycles of `sens_trig`.
- `dist_out`/`valid`/`err_out` update on the edge ending CAPTURE, one cycle after busy is seen low. `scan_done` is high in that same cycle.
- Minimum per-sensor period: 1 + t_start + t_busy + 1 + GUARD_CYCLES cycles.
- At most one bit of `sens_trig` is ever high, and never while any sensor is being serviced.

## Structure
- Shared package `mobility_pkg`: state encoding (IDLE, TRIG, WAIT_START, WAIT_DONE, CAPTURE, GUARD), `DIST_W`=16, `TIMER_W`=22.
- One natural sub-module, `ultrasonic_result_reg`: per-sensor capture register holding dist/valid/err plus the obstacle compare. It is instantiated N_SENSORS times; the sequencer FSM stays in the top.

## Test plan
All scenarios use GUARD_CYCLES=20 and behavioural sensor models.
- Normal scan, N=4, sensors return 100/200/300/400 with err=0, thresh=250 -> `dist_out` = {400,300,200,100}, `valid`=4'b1111, `obstacle`=4'b0011, one `scan_done` after sensor 3.
- Sensor 2 never raises busy -> `err_out[2]`=1 and `valid[2]`=0 after 8 cycles in WAIT_START; scan continues to sensor 3.
- Sensor 1 asserts err with busy low -> `err_out[1]`=1, `dist_out[1]` holds its previous value; the next good reading of 150 restores `valid[1]`=1, `err_out[1]`=0.
- `rst` during WAIT_DONE of sensor 2 -> all outputs 0 next cycle. With sensor 0 held busy, `sens_trig` stays 0 until busy drops.
- `enable` dropped during WAIT_DONE of sensor 1 -> sensor 1 is captured and guarded, then no further `sens_trig`. `cur_sensor`=2.
- Distance equal to thresh (250) -> `obstacle`=0; 249 -> `obstacle`=1.
